// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined add/sub datapath.
// Saturation (PIPELINED_ADDSUB_SATURATE_EN) uses the clamp-pattern helpers below.
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Upper bound on WIDTH for the clamp-pattern helpers; results are truncated by the caller.
  localparam int unsigned ClampMaxWidth = 256;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic logic [ClampMaxWidth-1:0] max_pos_pattern(input int unsigned width);
    return (ClampMaxWidth'(1) << (width - 1)) - ClampMaxWidth'(1);
  endfunction

  function automatic logic [ClampMaxWidth-1:0] max_neg_pattern(input int unsigned width);
    return ClampMaxWidth'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational ripple-carry slice; b_i arrives already conditioned for subtraction.
module addsub_slice #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] s_o,
  output logic             c_msb_o,
  output logic             cout_o
);

  always_comb begin
    logic carry;
    carry   = cin_i;
    c_msb_o = 1'b0;
    s_o     = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (i == Width - 1) c_msb_o = carry;
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor, carry chain split into STAGES registered slices.
// Define PIPELINED_ADDSUB_SATURATE_EN to clamp s on signed overflow.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW   = slice_width(WIDTH, STAGES);
  localparam int unsigned Last = STAGES - 1;

`ifdef PIPELINED_ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] MaxPos = WIDTH'(max_pos_pattern(WIDTH));
  localparam logic [WIDTH-1:0] MaxNeg = WIDTH'(max_neg_pattern(WIDTH));
`endif

  // Index k holds the state leaving stage k.
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_d   [STAGES];
  logic             cm_d  [STAGES];
  logic             sub_d [STAGES];
  logic             v_d   [STAGES];

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             cm_q  [STAGES];
  logic             sub_q [STAGES];
  logic             v_q   [STAGES];

  logic [WIDTH-1:0] s_out_d;
  logic             cout_d, ovf_d;
  logic             cout_q, ovf_q;
  logic             adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] stg_a, stg_b, stg_s, stg_s_o;
    logic             stg_c, stg_cm, stg_sub, stg_v;
    logic             stg_c_o, stg_cm_o;

    if (k == 0) begin : g_first
      assign stg_a   = a;
      assign stg_b   = (sub == ADD) ? b : ~b;
      assign stg_s   = '0;
      assign stg_c   = (sub == SUB);
      assign stg_cm  = 1'b0;
      assign stg_sub = sub;
      assign stg_v   = in_valid;
    end else begin : g_next
      assign stg_a   = a_q[k-1];
      assign stg_b   = b_q[k-1];
      assign stg_s   = s_q[k-1];
      assign stg_c   = c_q[k-1];
      assign stg_cm  = cm_q[k-1];
      assign stg_sub = sub_q[k-1];
      assign stg_v   = v_q[k-1];
    end

    // Stages past the top bit (when CW*STAGES overshoots WIDTH) only pass state through.
    if (k * CW < WIDTH) begin : g_slice
      localparam int unsigned Lo = k * CW;
      localparam int unsigned Hi = ((k + 1) * CW < WIDTH) ? (k + 1) * CW - 1 : WIDTH - 1;

      logic [Hi-Lo:0] sl_s;
      logic           sl_cmsb, sl_cout;

      addsub_slice #(
        .Width(Hi - Lo + 1)
      ) u_slice (
        .a_i    (stg_a[Hi:Lo]),
        .b_i    (stg_b[Hi:Lo]),
        .cin_i  (stg_c),
        .s_o    (sl_s),
        .c_msb_o(sl_cmsb),
        .cout_o (sl_cout)
      );

      always_comb begin
        stg_s_o        = stg_s;
        stg_s_o[Hi:Lo] = sl_s;
      end

      assign stg_c_o  = sl_cout;
      assign stg_cm_o = (Hi == WIDTH - 1) ? sl_cmsb : stg_cm;
    end else begin : g_empty
      assign stg_s_o  = stg_s;
      assign stg_c_o  = stg_c;
      assign stg_cm_o = stg_cm;
    end

    assign a_d[k]   = stg_a;
    assign b_d[k]   = stg_b;
    assign s_d[k]   = stg_s_o;
    assign c_d[k]   = stg_c_o;
    assign cm_d[k]  = stg_cm_o;
    assign sub_d[k] = stg_sub;
    assign v_d[k]   = stg_v;
  end

  always_comb begin
    cout_d  = c_d[Last] ^ sub_d[Last];
    ovf_d   = cm_d[Last] ^ c_d[Last];
    s_out_d = s_d[Last];
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    if (ovf_d) s_out_d = a_d[Last][WIDTH-1] ? MaxNeg : MaxPos;
`endif
  end

  // Whole-pipeline stall: every stage moves only when the output slot can drain.
  assign adv       = out_ready || !v_q[Last];
  assign in_ready  = adv;
  assign out_valid = v_q[Last];
  assign s         = s_q[Last];
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        cm_q[k]  <= 1'b0;
        sub_q[k] <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= (k == Last) ? s_out_d : s_d[k];
        c_q[k]   <= c_d[k];
        cm_q[k]  <= cm_d[k];
        sub_q[k] <= sub_d[k];
        v_q[k]   <= v_d[k];
      end
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule
